matrix_ls_seq: RTL and testbench
================================

MATRIX_LS_SEQ -- requirements
Module: matrix_ls_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address and word width of rs/stride.
REQ-002 SHALL have parameter ROWS, default 4, rows transferred per matrix command (ROWS >= 1).
REQ-003 SHALL have parameter IMM_W, default 11, immediate width (signed).
REQ-004 SHALL have parameter RD_W, default 5, matrix register index width.
REQ-005 SHALL have parameter QDEPTH, default 2, command queue entries (power of two, >= 1).
REQ-006 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port enable  input  1  command valid from issue queue.
REQ-009 SHALL have port ls_in  input  2  op: 2'b01 load, 2'b10 store, others illegal.
REQ-010 SHALL have ports rd_in [RD_W], rs_in [ADDR_W], stride_in [ADDR_W], imm_in [IMM_W], all inputs: destination/source register, base, row stride in bytes, offset.
REQ-011 SHALL have port cmd_ready  output  1  queue can accept a command this cycle.
REQ-012 SHALL have port mhit  input  1  scratchpad accepted the current row request.
REQ-013 SHALL have ports req_valid 1, req_ls 2, req_addr ADDR_W, req_rd RD_W, req_row clog2(ROWS) max 1, all outputs: row request to scratchpad.
REQ-014 SHALL have ports done 1, done_rd RD_W, done_ls 2, all outputs: command completion pulse.
REQ-015 SHALL have ports busy 1, illegal 1, both outputs: queue non-empty or engine active; one-cycle pulse on rejected illegal op.

Function
REQ-016 A command SHALL be accepted iff enable && cmd_ready && ls_in is 01 or 10; accepted commands are pushed with base = rs_in + sign-extended imm_in, modulo 2^ADDR_W.
REQ-017 cmd_ready SHALL equal (queue count < QDEPTH) from registered count; no same-cycle pop bypass, so a push while full is refused even if a pop occurs.
REQ-018 enable with ls_in 00 or 11 SHALL NOT push and SHALL pulse illegal the next cycle; the queue is unchanged.
REQ-019 Engine states SHALL be IDLE, ISSUE, DONE.
REQ-020 IDLE -> ISSUE when queue non-empty, at the edge after the entry becomes visible; command accepted at edge t into an empty idle unit shows req_valid from t+1.
REQ-021 In ISSUE, req_valid=1, req_ls/req_rd from queue head, req_addr = base + row*stride modulo 2^ADDR_W, req_row = row counter.
REQ-022 req_* SHALL hold stable while req_valid && !mhit; mhit is ignored outside ISSUE.
REQ-023 On mhit in ISSUE: if row < ROWS-1, row increments and state stays ISSUE; if row == ROWS-1, row clears and state -> DONE.
REQ-024 DONE SHALL last one cycle: done=1, done_rd/done_ls from head, req_valid=0, head popped at the end of the cycle.
REQ-025 DONE -> ISSUE if queue holds another entry after the pop (including one pushed in the DONE cycle), else IDLE.
REQ-026 stride 0 SHALL repeat base for every row; negative strides wrap via two's complement.
REQ-027 busy SHALL be 1 when state != IDLE or queue count != 0.
REQ-028 All outputs SHALL be registered or decoded from registered state only; no combinational path from mhit or enable to any output.

Reset
REQ-029 RST high SHALL immediately force state IDLE, row 0, queue empty, and req_valid, done, illegal, busy to 0, cmd_ready to 1, and all data outputs to 0.
REQ-030 RST asserted mid-command SHALL abort it with no done pulse; no queued command survives reset.

Verification
REQ-031 Load, rs=0x1000, imm=0x10, stride=0x40, ROWS=4, mhit always 1 -> req_addr 0x1010,0x1050,0x1090,0x10D0 on consecutive cycles, then done with done_rd=rd_in.
REQ-032 Store, imm=-16 (0x7F0), rs=0x8, stride=0xFFFFFFF8 -> addresses 0xFFFFFFF8,0xFFFFFFF0,0xFFFFFFE8,0xFFFFFFE0.
REQ-033 mhit held low 5 cycles on row 1 -> req_addr/req_row stable for all 5 cycles, no done until the remaining rows complete.
REQ-034 QDEPTH=2, three back-to-back enables -> third sees cmd_ready=0 and is refused; two done pulses arrive in order; cmd_ready returns to 1 the cycle after the first DONE.
REQ-035 ls_in=2'b11 with enable -> illegal pulse, no req_valid, busy stays 0.
REQ-036 RST during row 2 -> req_valid and busy go 0 at once, no done, and a new command afterwards starts at row 0.

Source files
------------

// File: rtl/matrix_ls_seq.sv
// Matrix load/store sequencer: queues commands and issues ROWS row requests each, then a done pulse.
// First request one cycle after the queued entry is visible; requests hold while mhit is low, cmd_ready drops when the queue is full.
module matrix_ls_seq #(
  parameter int ADDR_W = 32,
  parameter int ROWS   = 4,
  parameter int IMM_W  = 11,
  parameter int RD_W   = 5,
  parameter int QDEPTH = 2,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic [1:0]        ls_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [ADDR_W-1:0] rs_in,
  input  logic [ADDR_W-1:0] stride_in,
  input  logic [IMM_W-1:0]  imm_in,
  output logic              cmd_ready,
  input  logic              mhit,
  output logic              req_valid,
  output logic [1:0]        req_ls,
  output logic [ADDR_W-1:0] req_addr,
  output logic [RD_W-1:0]   req_rd,
  output logic [ROW_W-1:0]  req_row,
  output logic              done,
  output logic [RD_W-1:0]   done_rd,
  output logic [1:0]        done_ls,
  output logic              busy,
  output logic              illegal
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] LS_LOAD  = 2'b01;
  localparam logic [1:0] LS_STORE = 2'b10;

  localparam logic [CW-1:0]    DEPTH_C  = CW'(QDEPTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [PW-1:0]    LAST_PTR = PW'(QDEPTH - 1);

  typedef struct packed {
    logic [1:0]        ls;
    logic [RD_W-1:0]   rd;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
  } cmd_t;

  cmd_t              mem_q [QDEPTH];
  cmd_t              mem_d [QDEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic              illegal_q, illegal_d;

  cmd_t head;
  cmd_t new_cmd;
  logic ls_ok;
  logic push;
  logic pop;

  always_comb begin
    ls_ok          = (ls_in == LS_LOAD) || (ls_in == LS_STORE);
    push           = enable && cmd_ready && ls_ok;
    pop            = (state_q == S_DONE);
    illegal_d      = enable && !ls_ok;
    new_cmd.ls     = ls_in;
    new_cmd.rd     = rd_in;
    new_cmd.base   = rs_in + {{(ADDR_W - IMM_W){imm_in[IMM_W-1]}}, imm_in};
    new_cmd.stride = stride_in;
    head           = mem_q[rd_ptr_q];
  end

  // Count is refreshed from registered state only, so a pop never frees a slot in its own cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_cmd;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Row address is base plus a running offset, avoiding a row*stride multiplier.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (mhit) begin
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            off_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d = row_q + ROW_W'(1);
            off_d = off_q + head.stride;
          end
        end
      end
      S_DONE: begin
        state_d = (cnt_d != '0) ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      row_q     <= '0;
      off_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      row_q     <= row_d;
      off_q     <= off_d;
      illegal_q <= illegal_d;
    end
  end

  // Data outputs are gated to zero outside their valid state so reset and idle look identical.
  always_comb begin
    cmd_ready = (cnt_q < DEPTH_C);
    req_valid = (state_q == S_ISSUE);
    req_ls    = req_valid ? head.ls : '0;
    req_rd    = req_valid ? head.rd : '0;
    req_addr  = req_valid ? (head.base + off_q) : '0;
    req_row   = row_q;
    done      = (state_q == S_DONE);
    done_rd   = done ? head.rd : '0;
    done_ls   = done ? head.ls : '0;
    busy      = (state_q != S_IDLE) || (cnt_q != '0);
    illegal   = illegal_q;
  end

endmodule

// File: tb/tb_matrix_ls_seq.sv
// Bench for matrix_ls_seq: vector table plus hand sequences, with a request/done scoreboard.
module tb_matrix_ls_seq;

  logic        CLK, RST;
  logic        enable, mhit;
  logic [1:0]  ls_in;
  logic [4:0]  rd_in;
  logic [31:0] rs_in, stride_in;
  logic [10:0] imm_in;
  logic        cmd_ready, req_valid, done, busy, illegal;
  logic [1:0]  req_ls, done_ls, req_row;
  logic [31:0] req_addr;
  logic [4:0]  req_rd, done_rd;

  int tests = 0;
  int fails = 0;
  int cyc;

  typedef struct packed {
    logic [1:0]  ls;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [1:0]  row;
  } req_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [1:0] ls;
  } dn_t;

  typedef struct packed {
    logic [1:0]       ls;
    logic [4:0]       rd;
    logic [31:0]      rs;
    logic [31:0]      stride;
    logic [10:0]      imm;
    logic [3:0][31:0] exp_a;
  } vec_t;

  req_t exp_req[$];
  dn_t  exp_dn[$];
  req_t mon_r;
  dn_t  mon_d;
  vec_t vecs[5];

  matrix_ls_seq dut (
    .CLK(CLK), .RST(RST), .enable(enable), .ls_in(ls_in), .rd_in(rd_in),
    .rs_in(rs_in), .stride_in(stride_in), .imm_in(imm_in), .cmd_ready(cmd_ready),
    .mhit(mhit), .req_valid(req_valid), .req_ls(req_ls), .req_addr(req_addr),
    .req_rd(req_rd), .req_row(req_row), .done(done), .done_rd(done_rd),
    .done_ls(done_ls), .busy(busy), .illegal(illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] ls, input logic [4:0] rd, input logic [31:0] rs,
                      input logic [31:0] stride, input logic [10:0] imm);
    enable = 1'b1; ls_in = ls; rd_in = rd; rs_in = rs; stride_in = stride; imm_in = imm;
    step();
    enable = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] ls, input logic [4:0] rd, input logic [31:0] rs,
                          input logic [31:0] stride, input logic [10:0] imm);
    logic [31:0] base;
    logic [31:0] a;
    base = rs + {{21{imm[10]}}, imm};
    for (int r = 0; r < 4; r++) begin
      a = base + stride * 32'(r);
      exp_req.push_back(req_t'{ls, rd, a, 2'(r)});
    end
    exp_dn.push_back(dn_t'{rd, ls});
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check("done_seen", done, 1);
  endtask

  // Requests are consumed only on cycles where the handshake will complete.
  always @(negedge CLK) begin
    if (!RST) begin
      if (req_valid && mhit) begin
        if (exp_req.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_req: got addr 0x%0h row %0d, none expected", req_addr, req_row);
        end else begin
          mon_r = exp_req.pop_front();
          check("req_addr", req_addr, mon_r.addr);
          check("req_row", req_row, mon_r.row);
          check("req_ls", req_ls, mon_r.ls);
          check("req_rd", req_rd, mon_r.rd);
        end
      end
      if (done) begin
        if (exp_dn.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got rd %0d, none expected", done_rd);
        end else begin
          mon_d = exp_dn.pop_front();
          check("done_rd", done_rd, mon_d.rd);
          check("done_ls", done_ls, mon_d.ls);
          check("done_no_req", req_valid, 0);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{ls: 2'b01, rd: 5'd3, rs: 32'h1000, stride: 32'h40, imm: 11'h010,
                exp_a: {32'h10D0, 32'h1090, 32'h1050, 32'h1010}};
    vecs[1] = '{ls: 2'b10, rd: 5'd9, rs: 32'h8, stride: 32'hFFFF_FFF8, imm: 11'h7F0,
                exp_a: {32'hFFFF_FFE0, 32'hFFFF_FFE8, 32'hFFFF_FFF0, 32'hFFFF_FFF8}};
    vecs[2] = '{ls: 2'b01, rd: 5'd17, rs: 32'h2000, stride: 32'h0, imm: 11'h004,
                exp_a: {32'h2004, 32'h2004, 32'h2004, 32'h2004}};
    vecs[3] = '{ls: 2'b10, rd: 5'd31, rs: 32'hFFFF_FFF0, stride: 32'h10, imm: 11'h020,
                exp_a: {32'h40, 32'h30, 32'h20, 32'h10}};
    vecs[4] = '{ls: 2'b01, rd: 5'd0, rs: 32'h100, stride: 32'h100, imm: 11'h400,
                exp_a: {32'h0, 32'hFFFF_FF00, 32'hFFFF_FE00, 32'hFFFF_FD00}};

    RST = 1'b1; enable = 1'b0; mhit = 1'b1; ls_in = 2'b00; rd_in = '0;
    rs_in = '0; stride_in = '0; imm_in = '0;
    step(); step();
    check("rst_req_valid", req_valid, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_req_addr", req_addr, 0);
    check("rst_req_row", req_row, 0);
    check("rst_done_rd", done_rd, 0);
    RST = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < 4; r++)
        exp_req.push_back(req_t'{vecs[i].ls, vecs[i].rd, vecs[i].exp_a[r], 2'(r)});
      exp_dn.push_back(dn_t'{vecs[i].rd, vecs[i].ls});
      send(vecs[i].ls, vecs[i].rd, vecs[i].rs, vecs[i].stride, vecs[i].imm);
      check("accept_edge_no_req", req_valid, 0);
      check("accept_edge_busy", busy, 1);
      step();
      check("first_req_valid", req_valid, 1);
      wait_done(20, cyc);
      check("done_latency", cyc, 4);
      step();
      check("idle_after_done", busy, 0);
    end

    // Illegal ops: no push, one-cycle illegal pulse.
    send(2'b11, 5'd4, 32'h4000, 32'h4, 11'h0);
    check("illegal_pulse_11", illegal, 1);
    check("illegal_busy", busy, 0);
    check("illegal_no_req", req_valid, 0);
    step();
    check("illegal_clear", illegal, 0);
    check("illegal_busy_after", busy, 0);
    check("illegal_no_req_after", req_valid, 0);
    send(2'b00, 5'd4, 32'h4000, 32'h4, 11'h0);
    check("illegal_pulse_00", illegal, 1);
    step();
    check("illegal_00_busy", busy, 0);

    // Stall on row 1 for five cycles.
    push_exp(2'b01, 5'd7, 32'h3000, 32'h10, 11'h0);
    send(2'b01, 5'd7, 32'h3000, 32'h10, 11'h0);
    step();
    step();
    check("stall_row_reached", req_row, 1);
    mhit = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_addr", req_addr, 32'h3010);
      check("stall_row", req_row, 1);
      check("stall_valid", req_valid, 1);
      check("stall_no_done", done, 0);
    end
    mhit = 1'b1;
    wait_done(20, cyc);
    check("stall_tail_latency", cyc, 3);
    step();

    // Three back-to-back commands into a two-entry queue.
    push_exp(2'b01, 5'd10, 32'h6000, 32'h8, 11'h0);
    push_exp(2'b10, 5'd11, 32'h7000, 32'h4, 11'h1);
    enable = 1'b1; ls_in = 2'b01; rd_in = 5'd10; rs_in = 32'h6000; stride_in = 32'h8; imm_in = 11'h0;
    check("full_ready_a", cmd_ready, 1);
    step();
    ls_in = 2'b10; rd_in = 5'd11; rs_in = 32'h7000; stride_in = 32'h4; imm_in = 11'h1;
    check("full_ready_b", cmd_ready, 1);
    step();
    ls_in = 2'b01; rd_in = 5'd12; rs_in = 32'h9000; stride_in = 32'h4; imm_in = 11'h0;
    check("full_ready_c", cmd_ready, 0);
    step();
    enable = 1'b0;
    wait_done(30, cyc);
    check("ready_in_done", cmd_ready, 0);
    step();
    check("ready_after_done", cmd_ready, 1);
    check("second_issue_direct", req_valid, 1);
    wait_done(30, cyc);
    step();
    step();
    check("full_drained_busy", busy, 0);

    // Reset in the middle of a command.
    push_exp(2'b01, 5'd20, 32'h5000, 32'h20, 11'h0);
    send(2'b01, 5'd20, 32'h5000, 32'h20, 11'h0);
    step(); step(); step();
    check("rst_mid_row2", req_row, 2);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_req_valid", req_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_row", req_row, 0);
    check("rst_mid_ready", cmd_ready, 1);
    exp_req.delete();
    exp_dn.delete();
    step();
    RST = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("rst_no_survivor", busy, 0);
    push_exp(2'b10, 5'd21, 32'hA000, 32'h100, 11'h0);
    send(2'b10, 5'd21, 32'hA000, 32'h100, 11'h0);
    step();
    check("post_rst_row0", req_row, 0);
    check("post_rst_addr", req_addr, 32'hA000);
    wait_done(20, cyc);
    step();

    check("req_queue_drained", exp_req.size(), 0);
    check("done_queue_drained", exp_dn.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
